// File: rtl/decim_avg_fifo.sv
// Decimating accumulate-and-dump averager with a small output FIFO.
// Averages every DECIM strobed samples (floor) and queues results for a valid/ready sink.
module decim_avg_fifo #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DECIM      = 8,
  parameter int unsigned LOG2_DECIM = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic                        merge_finished_i,
  input  logic [WIDTH-1:0]            data_i,
  output logic [WIDTH-1:0]            data_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [$clog2(FIFO_DEPTH):0] level_o,
  output logic                        overflow_o
);

  localparam int unsigned AW = WIDTH + LOG2_DECIM;
  localparam int unsigned CW = LOG2_DECIM;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;

  logic                 stb;
  logic                 last;
  logic                 dump;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_sum;
  logic [CW-1:0]        phase;
  logic [WIDTH-1:0]     result;

  logic [WIDTH-1:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_next;
  logic [LW-1:0]        level_next;
  logic [WIDTH-1:0]     head_next;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 drop;

  assign stb     = start_i & merge_finished_i;
  assign last    = (phase == CW'(DECIM - 1));
  assign dump    = stb & last;
  assign acc_sum = acc + AW'($signed(data_i));
  // Arithmetic shift floors toward -inf; the average always fits in WIDTH bits.
  assign result  = WIDTH'(acc_sum >>> LOG2_DECIM);

  // Accumulator and phase; start_i low flushes any partial block.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      phase <= '0;
    end else if (!start_i) begin
      acc   <= '0;
      phase <= '0;
    end else if (stb) begin
      if (last) begin
        acc   <= '0;
        phase <= '0;
      end else begin
        acc   <= acc_sum;
        phase <= phase + CW'(1);
      end
    end
  end

  assign full = (level_o == LW'(FIFO_DEPTH));
  assign pop  = valid_o & ready_i;
  // A full FIFO still accepts a result when the head leaves in the same cycle.
  assign push = dump & (~full | pop);
  assign drop = dump & full & ~pop;

  // Next occupancy, read pointer and head word so the outputs can be registered.
  always_comb begin
    rd_next    = rd_ptr;
    level_next = level_o;
    head_next  = '0;
    if (pop) begin
      rd_next = rd_ptr + PW'(1);
    end
    case ({push, pop})
      2'b10:   level_next = level_o + LW'(1);
      2'b01:   level_next = level_o - LW'(1);
      default: level_next = level_o;
    endcase
    if (level_next != '0) begin
      // The new head is the slot being written only when it is the sole entry.
      if (push && (wr_ptr == rd_next)) begin
        head_next = result;
      end else begin
        head_next = mem[rd_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level_o    <= '0;
      valid_o    <= 1'b0;
      data_o     <= '0;
      overflow_o <= 1'b0;
    end else begin
      rd_ptr  <= rd_next;
      level_o <= level_next;
      valid_o <= (level_next != '0);
      data_o  <= head_next;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (drop) begin
        overflow_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_decim_avg_fifo.sv
// Scoreboard bench for decim_avg_fifo: expected averages are queued when blocks
// are driven and compared whenever the sink accepts a word.
module tb_decim_avg_fifo;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        merge_finished_i;
  logic [15:0] data_i;
  logic [15:0] data_o;
  logic        valid_o;
  logic        ready_i;
  logic [2:0]  level_o;
  logic        overflow_o;

  int          n_checks;
  int          n_pass;
  logic [15:0] sb[$];

  decim_avg_fifo #(
    .WIDTH(16), .DECIM(8), .LOG2_DECIM(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start_i),
    .merge_finished_i(merge_finished_i),
    .data_i(data_i),
    .data_o(data_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .level_o(level_o),
    .overflow_o(overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Sink side: every accepted word must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && valid_o && ready_i) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(valid_o), 32'd0);
      end else begin
        logic [15:0] e;
        e = sb.pop_front();
        check("data", 32'(data_o), 32'(e));
      end
    end
  end

  task automatic drive_sample(input logic [15:0] d);
    start_i          = 1'b1;
    merge_finished_i = 1'b1;
    data_i           = d;
    @(posedge clk);
    #1;
    merge_finished_i = 1'b0;
  endtask

  task automatic idle(input int n);
    merge_finished_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic const_block(input int v, input bit keep);
    for (int i = 0; i < 8; i++) drive_sample(16'(v));
    if (keep) sb.push_back(16'(v));
  endtask

  task automatic list_block(input int s[8]);
    int sum;
    sum = 0;
    for (int i = 0; i < 8; i++) begin
      sum += s[i];
      drive_sample(16'(s[i]));
    end
    sb.push_back(16'(sum >>> 3));
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    ready_i          = 1'b0;
    merge_finished_i = 1'b0;
    rst              = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    int s[8];
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1; start_i = 1'b0; merge_finished_i = 1'b0; data_i = '0; ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_level", 32'(level_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_ovf", 32'(overflow_o), 32'd0);
    rst = 1'b0;

    // Constant input: one result, one cycle after the 8th strobe edge.
    ready_i = 1'b1;
    for (int i = 0; i < 7; i++) drive_sample(16'd100);
    check("no_early", 32'(valid_o), 32'd0);
    drive_sample(16'd100);
    sb.push_back(16'd100);
    check("lat_valid", 32'(valid_o), 32'd1);
    check("lat_data", 32'(data_o), 32'd100);
    idle(1);
    check("single_pulse", 32'(valid_o), 32'd0);

    // Negative floor and extremes.
    for (int i = 0; i < 8; i++) s[i] = i - 8;
    list_block(s);
    for (int i = 0; i < 8; i++) s[i] = 32767;
    list_block(s);
    for (int i = 0; i < 8; i++) s[i] = -32768;
    list_block(s);
    for (int i = 0; i < 8; i++) s[i] = (i % 2 == 0) ? 32767 : -32768;
    list_block(s);
    drain("drain_basic");

    // Flush with strobes held high while start_i is low.
    for (int i = 0; i < 3; i++) drive_sample(16'd500);
    start_i = 1'b0;
    merge_finished_i = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 8; i++) drive_sample(16'd10);
    sb.push_back(16'd10);
    drain("drain_flush");

    // Backpressure: fifth result is dropped.
    ready_i = 1'b0;
    for (int v = 1; v <= 5; v++) const_block(v, v <= 4);
    check("ovf_level", 32'(level_o), 32'd4);
    check("ovf_flag", 32'(overflow_o), 32'd1);
    ready_i = 1'b1;
    drain("drain_ovf");
    idle(2);
    check("ovf_sticky", 32'(overflow_o), 32'd1);
    check("ovf_empty", 32'(valid_o), 32'd0);

    do_reset();
    check("rst2_ovf", 32'(overflow_o), 32'd0);
    check("rst2_level", 32'(level_o), 32'd0);

    // Full FIFO with push and pop at the same edge.
    for (int v = 11; v <= 14; v++) const_block(v, 1'b1);
    check("full_level", 32'(level_o), 32'd4);
    for (int i = 0; i < 7; i++) drive_sample(16'd15);
    ready_i = 1'b1;
    drive_sample(16'd15);
    sb.push_back(16'd15);
    check("pp_level", 32'(level_o), 32'd4);
    check("pp_ovf", 32'(overflow_o), 32'd0);
    drain("drain_pp");

    // Reset mid-accumulation with entries queued.
    ready_i = 1'b0;
    const_block(21, 1'b1);
    const_block(22, 1'b1);
    for (int i = 0; i < 5; i++) drive_sample(16'd9);
    check("pre_rst_level", 32'(level_o), 32'd2);
    do_reset();
    check("mid_rst_valid", 32'(valid_o), 32'd0);
    check("mid_rst_level", 32'(level_o), 32'd0);
    check("mid_rst_ovf", 32'(overflow_o), 32'd0);
    check("mid_rst_data", 32'(data_o), 32'd0);
    ready_i = 1'b1;
    const_block(7, 1'b1);
    drain("drain_rst");
    idle(3);
    check("final_empty", 32'(valid_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
